// File: rtl/p2s_rx_sched_pkg.sv
// Shared types and constants for the P2S receive scheduler.
// err width depends on P2S_RX_TIMEOUT_EN (adds the timeout flag).
package p2s_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RECV,
        DRAIN
    } state_e;

    localparam int unsigned ERR_SPURIOUS = 0;
    localparam int unsigned ERR_SHORT    = 1;
    localparam int unsigned ERR_OVERFLOW = 2;
    localparam int unsigned ERR_TIMEOUT  = 3;

`ifdef P2S_RX_TIMEOUT_EN
    localparam int unsigned ERR_W = 4;
`else
    localparam int unsigned ERR_W = 3;
`endif

endpackage

// File: rtl/p2s_rx_sched_if.sv
// Packed-word output stream from the scheduler to the parallel sink.
// out_ready is advisory: the stream never stalls.
interface p2s_rx_sched_if #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned WORD = 32
);
    localparam int unsigned IW = $clog2(NCH);

    logic [WORD-1:0] out_word;
    logic            out_valid;
    logic            out_last;
    logic [IW-1:0]   out_ch;
    logic            out_ready;

    modport master (
        output out_word, out_valid, out_last, out_ch,
        input  out_ready
    );

    modport slave (
        input  out_word, out_valid, out_last, out_ch,
        output out_ready
    );
endinterface

// File: rtl/p2s_rx_sched_arb.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping around NCH channels.
module rr_arb_nch #(
    parameter int unsigned NCH = 2,
    parameter int unsigned IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [IW-1:0]  gnt,
    output logic           any
);
    logic [IW-1:0] idx;

    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = IW'((32'(ptr) + i) % NCH);
            if (!any && req[idx]) begin
                gnt = idx;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/p2s_rx_sched.sv
// Round-robin scheduler gating NCH P2S channels onto one word stream.
// Optional P2S_RX_TIMEOUT_EN adds TMO and err[timeout] for GRANT/DRAIN.
module p2s_rx_sched
    import p2s_sched_pkg::*;
#(
    parameter int unsigned NCH   = 2,
    parameter int unsigned WIDTH = 512,
    parameter int unsigned WORD  = 32
`ifdef P2S_RX_TIMEOUT_EN
    ,
    parameter int unsigned TMO   = 1024
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NCH-1:0]   ch_req,
    input  logic [NCH-1:0]   ch_valid,
    input  logic [NCH-1:0]   ch_data,
    output logic [NCH-1:0]   ch_ki_b,
    p2s_rx_sched_if.master   sink,
    output logic [ERR_W-1:0] err,
    input  logic             err_clr
);
    localparam int unsigned IW = $clog2(NCH);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = (WORD > 1) ? $clog2(WORD) : 1;
    localparam logic [IW-1:0] LAST_CH = IW'(NCH - 1);

    state_e          state;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   pos;
    logic [WORD-1:0] acc;
    logic [WORD-1:0] word_q;
    logic            valid_q;
    logic            last_q;
    logic [IW-1:0]   ch_q;

    logic [IW-1:0]    pick;
    logic             any;
    logic             vld_g;
    logic             bit_in;
    logic [NCH-1:0]   gnt_mask;
    logic [WORD-1:0]  word_nxt;
    logic [CW-1:0]    cnt_inc;
    logic             word_done;
    logic             burst_done;
    logic [IW-1:0]    ptr_nxt;
    logic [ERR_W-1:0] err_set;

`ifdef P2S_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TMO + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
`endif

    rr_arb_nch #(.NCH(NCH)) u_arb (
        .req (ch_req),
        .ptr (ptr),
        .gnt (pick),
        .any (any)
    );

    assign vld_g      = ch_valid[gnt];
    assign bit_in     = ch_data[gnt];
    assign cnt_inc    = cnt + CW'(1);
    assign word_done  = (pos == PW'(WORD - 1));
    assign burst_done = (cnt_inc == CW'(WIDTH));
    assign ptr_nxt    = (gnt == LAST_CH) ? '0 : gnt + IW'(1);

    always_comb begin
        word_nxt      = acc;
        word_nxt[pos] = bit_in;
    end

    always_comb begin
        gnt_mask = '0;
        if (state != IDLE) gnt_mask[gnt] = 1'b1;
    end

`ifdef P2S_RX_TIMEOUT_EN
    assign tmo_hit = (((state == GRANT) && !vld_g) || ((state == DRAIN) && vld_g))
                     && (tmo_cnt == TW'(TMO - 1));
`endif

    always_comb begin
        err_set               = '0;
        err_set[ERR_SPURIOUS] = |(ch_valid & ~gnt_mask);
        err_set[ERR_SHORT]    = (state == RECV) && !vld_g;
        err_set[ERR_OVERFLOW] = valid_q && !sink.out_ready;
`ifdef P2S_RX_TIMEOUT_EN
        err_set[ERR_TIMEOUT]  = tmo_hit;
`endif
    end

    // ch_ki_b is registered on the same edges that enter/leave GRANT and RECV,
    // so it tracks the state decode cycle-for-cycle without a comb path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            gnt     <= '0;
            ptr     <= '0;
            cnt     <= '0;
            pos     <= '0;
            acc     <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ch_q    <= '0;
            ch_ki_b <= '1;
            err     <= '0;
`ifdef P2S_RX_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err     <= (err & ~{ERR_W{err_clr}}) | err_set;
            case (state)
                IDLE: begin
                    if (any) begin
                        gnt     <= pick;
                        ch_ki_b <= ~(NCH'(1) << pick);
                        cnt     <= '0;
                        pos     <= '0;
                        state   <= GRANT;
`ifdef P2S_RX_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                GRANT, RECV: begin
                    if (vld_g) begin
                        acc <= word_nxt;
                        cnt <= cnt_inc;
                        pos <= word_done ? '0 : pos + PW'(1);
                        if (word_done) begin
                            word_q  <= word_nxt;
                            valid_q <= 1'b1;
                            last_q  <= burst_done;
                            ch_q    <= gnt;
                        end
                        if (burst_done) begin
                            ch_ki_b <= '1;
                            state   <= DRAIN;
`ifdef P2S_RX_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
                            state <= RECV;
                        end
                    end else if (state == RECV) begin
                        ch_ki_b <= '1;
                        state   <= DRAIN;
`ifdef P2S_RX_TIMEOUT_EN
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        ch_ki_b <= '1;
                        ptr     <= ptr_nxt;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
`endif
                    end
                end
                DRAIN: begin
                    if (!vld_g) begin
                        ptr   <= ptr_nxt;
                        state <= IDLE;
`ifdef P2S_RX_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        ptr   <= ptr_nxt;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sink.out_word  = word_q;
    assign sink.out_valid = valid_q;
    assign sink.out_last  = last_q;
    assign sink.out_ch    = ch_q;
endmodule

// File: doc/p2s_rx_sched.md
Name: p2s_rx_sched

Overview:
- Round-robin scheduler for NCH MTD3L-to-synchronous P2S channels that share one synchronous parallel sink.
- Per channel, it gates the MTD3L token through the channel's ki_b input and grants one channel at a time.
- It captures the granted channel's serial burst (data_valid/data_out) and packs it into WORD-bit words tagged with the channel ID.
- Sits on the sync side next to the P2S instances and replaces the direct ki_b = data_valid tie-off.

Parameters:
- NCH, 2, number of P2S channels (>=2)
- WIDTH, 512, bits per burst; must equal the P2S channel width
- WORD, 32, output word width; WIDTH % WORD == 0

Ports:
- clk  in  1  sync clock, the same clock that drives the P2S channels
- reset_n  in  1  asynchronous, active-low reset
- ch_req  in  NCH  channel c has a token pending upstream (level)
- ch_valid  in  NCH  data_valid from each P2S channel
- ch_data  in  NCH  data_out from each P2S channel
- ch_ki_b  out  NCH  ki_b to each P2S channel
- out_word  out  WORD  packed word, LSB = earliest bit
- out_valid  out  1  one-cycle strobe per word
- out_last  out  1  final word of the burst; qualified by out_valid
- out_ch  out  $clog2(NCH)  channel ID of out_word
- out_ready  in  1  sink can accept; advisory only, the stream cannot stall
- err  out  3  sticky flags {overflow, short, spurious}
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (asynchronous on reset_n low):
  - ch_ki_b all 1; out_valid, out_last, out_word, out_ch, err = 0.
  - FSM = IDLE; round-robin pointer = 0; bit counter = 0.
- ch_ki_b[c] = 0 only for the granted channel while in GRANT or RECV; otherwise 1. This means ki = 0 and the MTD3L stage requests NULL.
- FSM states:
  - IDLE: if any ch_req is set, select the first requester at or after the pointer (wrapping). Register the grant and go to GRANT. If none, stay in IDLE.
  - GRANT: wait for ch_valid[g] = 1. The data bit is sampled in the same cycle as the first cycle of valid. Go to RECV with count = 1.
  - RECV:
    - Each cycle with ch_valid[g] = 1, shift ch_data[g] into bit position (count % WORD) and increment count.
    - When count % WORD wraps to 0, pulse out_valid for one cycle with the completed word.
    - out_last = 1 when count reaches WIDTH.
    - At count == WIDTH, drive ch_ki_b[g] = 1 and go to DRAIN.
  - DRAIN: wait for ch_valid[g] = 0. Then advance the pointer to g+1 mod NCH and go to IDLE.
- Latency:
  - Word output registers 1 cycle after its last bit is sampled.
  - Burst-to-next-grant is at least 2 cycles (DRAIN, IDLE).
- Boundary conditions:
  - ch_valid[g] falls in RECV before count == WIDTH: set err[short]. Drop the partial word (no out_valid), release ki_b and go to DRAIN, which exits at once.
  - ch_valid[c] = 1 for a non-granted c, in any state: set err[spurious]. The grant is unchanged.
  - out_valid while out_ready = 0: set err[overflow]. The word is still presented for exactly 1 cycle.
  - Simultaneous requests are resolved by the round-robin pointer. A channel that just finished has the lowest priority.
  - ch_req dropping during GRANT does not abort the grant.
  - err_clr in the same cycle as a new error: the new error wins and the flag stays set.
  - Counter width is $clog2(WIDTH)+1. The count never exceeds WIDTH.
  - reset_n asserted mid-burst returns everything to reset values immediately. No out_valid is issued for the partial burst.

Optional Feature:
- Macro P2S_RX_TIMEOUT_EN.
- Defined:
  - Adds a parameter TMO (default 1024) and a 4th err bit, err[timeout]. The err port becomes 4 bits.
  - A cycle counter runs in GRANT and DRAIN. On reaching TMO, set err[timeout], force ch_ki_b[g] = 1, advance the pointer and go to IDLE.
- Undefined: no counter; GRANT and DRAIN wait indefinitely; err is 3 bits.

Decomposition:
- Shared package p2s_sched_pkg holds:
  - typedef enum for the FSM states IDLE/GRANT/RECV/DRAIN
  - error-bit index localparams ERR_SPURIOUS = 0, ERR_SHORT = 1, ERR_OVERFLOW = 2, ERR_TIMEOUT = 3
- One sub-module, rr_arb_nch: a combinational round-robin picker that takes req and pointer and returns grant index and any.

Test Plan:
- NCH = 2, WIDTH = 64, WORD = 32; ch_req = 01; ch0 bursts 0xDEADBEEF_01234567 LSB first, out_ready = 1 -> ch_ki_b = 10 during burst; out_word = 0x01234567 then 0xDEADBEEF with out_last on the 2nd; out_ch = 0; err = 0.
- ch_req = 11 held; both channels send 64-bit bursts -> grants alternate 0,1,0,1; out_ch follows; no ch_ki_b overlap.
- ch0 valid drops after 40 bits -> err = 3'b010; one word (bits 0-31) output, no out_last; next grant proceeds normally.
- ch1 asserts valid while ch0 granted -> err[spurious] = 1; ch0 burst completes intact; err_clr -> err = 0.
- out_ready = 0 at second word -> err[overflow] = 1, word still strobed once; reset_n low mid-RECV -> all outputs 0, ch_ki_b = 11, next burst starts clean.
- With P2S_RX_TIMEOUT_EN, TMO = 16: grant ch0 with no valid -> after 16 cycles err[timeout] = 1, ch_ki_b[0] = 1, pointer moves to ch1.
